// File: rtl/crash_course_cpu_pkg.sv
// Shared types and instruction-field positions for the crash-course CPU sequencer.
package crash_course_cpu_pkg;

    localparam int REG_ADDR_WIDTH = 4;
    localparam int DATA_WIDTH     = 8;
    localparam int INSTR_WIDTH    = 16;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RA_MSB  = 11;
    localparam int RA_LSB  = 8;
    localparam int RB_MSB  = 7;
    localparam int RB_LSB  = 4;
    localparam int RC_MSB  = 3;
    localparam int RC_LSB  = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_LDI  = 4'h6,
        OP_MOV  = 4'h7,
        OP_JMP  = 4'h8,
        OP_BZ   = 4'h9,
        OP_ILLA = 4'hA,
        OP_ILLB = 4'hB,
        OP_ILLC = 4'hC,
        OP_ILLD = 4'hD,
        OP_ILLE = 4'hE,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_HALT
    } state_t;

endpackage

// File: rtl/crash_course_cpu_alu.sv
// Combinational 8-bit ALU; result is only meaningful for the writeback opcodes 1-7.
module crash_course_cpu_alu
    import crash_course_cpu_pkg::*;
(
    input  opcode_t               opcode,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  logic [DATA_WIDTH-1:0] op_c,
    input  logic [DATA_WIDTH-1:0] imm8,
    output logic [DATA_WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (opcode)
            OP_ADD:  result = op_b + op_c;
            OP_SUB:  result = op_b - op_c;
            OP_AND:  result = op_b & op_c;
            OP_OR:   result = op_b | op_c;
            OP_XOR:  result = op_b ^ op_c;
            OP_LDI:  result = imm8;
            OP_MOV:  result = op_b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/crash_course_cpu_sequencer.sv
// Fetch/decode/execute sequencer driving the register file ports.
// Optional retire counter enabled by CRASH_COURSE_CPU_RETIRE_COUNT_EN.
module crash_course_cpu_sequencer
    import crash_course_cpu_pkg::*;
#(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      async_rst_n,
    input  logic                      clk_en,
    input  logic                      start,
    output logic                      imem_req,
    output logic [PC_WIDTH-1:0]       imem_addr,
    input  logic                      imem_ack,
    input  logic [INSTR_WIDTH-1:0]    imem_data,
    output logic                      system_enabled,
    output logic [REG_ADDR_WIDTH-1:0] reg_a_addr,
    output logic                      reg_a_write_enable,
    output logic [DATA_WIDTH-1:0]     reg_a_write_data,
    output logic [REG_ADDR_WIDTH-1:0] reg_b_addr,
    input  logic [DATA_WIDTH-1:0]     reg_b_read_data,
    output logic [REG_ADDR_WIDTH-1:0] reg_c_addr,
    input  logic [DATA_WIDTH-1:0]     reg_c_read_data,
    output logic                      halted,
    output logic                      illegal_opcode
`ifdef CRASH_COURSE_CPU_RETIRE_COUNT_EN
    ,
    output logic [15:0]               retired_count
`endif
);

    state_t                   state_q, state_d;
    logic [PC_WIDTH-1:0]      pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
    logic [DATA_WIDTH-1:0]    op_b_q, op_b_d;
    logic [DATA_WIDTH-1:0]    op_c_q, op_c_d;
    logic [DATA_WIDTH-1:0]    imm8;
    logic [DATA_WIDTH-1:0]    alu_result;
    opcode_t                  op;
    logic                     taken;

    assign op   = opcode_t'(instr_q[OP_MSB:OP_LSB]);
    assign imm8 = instr_q[IMM_MSB:IMM_LSB];

    crash_course_cpu_alu u_alu (
        .opcode (op),
        .op_b   (op_b_q),
        .op_c   (op_c_q),
        .imm8   (imm8),
        .result (alu_result)
    );

    // BZ tests rA, so it is routed through read port B during decode.
    assign reg_a_addr = instr_q[RA_MSB:RA_LSB];
    assign reg_b_addr = (op == OP_BZ) ? instr_q[RA_MSB:RA_LSB] : instr_q[RB_MSB:RB_LSB];
    assign reg_c_addr = instr_q[RC_MSB:RC_LSB];
    assign taken      = (op == OP_JMP) || ((op == OP_BZ) && (op_b_q == '0));

    always_comb begin
        state_d            = state_q;
        pc_d               = pc_q;
        instr_d            = instr_q;
        op_b_d             = op_b_q;
        op_c_d             = op_c_q;
        imem_req           = 1'b0;
        imem_addr          = '0;
        system_enabled     = 1'b0;
        reg_a_write_enable = 1'b0;
        reg_a_write_data   = '0;
        halted             = 1'b0;
        illegal_opcode     = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                halted = (state_q == ST_HALT);
                if (clk_en && start) begin
                    pc_d    = RESET_PC;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                system_enabled = 1'b1;
                imem_req       = 1'b1;
                imem_addr      = pc_q;
                if (clk_en && imem_ack) begin
                    instr_d = imem_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                system_enabled = 1'b1;
                if (clk_en) begin
                    op_b_d  = reg_b_read_data;
                    op_c_d  = reg_c_read_data;
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                system_enabled = 1'b1;
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI, OP_MOV: begin
                        reg_a_write_enable = 1'b1;
                        reg_a_write_data   = alu_result;
                    end
                    OP_ILLA, OP_ILLB, OP_ILLC, OP_ILLD, OP_ILLE: illegal_opcode = 1'b1;
                    default: ;
                endcase
                if (clk_en) begin
                    pc_d    = taken ? PC_WIDTH'(imm8) : pc_q + PC_WIDTH'(1);
                    state_d = (op == OP_HALT) ? ST_HALT : ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            op_b_q  <= '0;
            op_c_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            op_b_q  <= op_b_d;
            op_c_q  <= op_c_d;
        end
    end

`ifdef CRASH_COURSE_CPU_RETIRE_COUNT_EN
    logic [15:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if (clk_en && start && (state_q == ST_IDLE || state_q == ST_HALT))
            retired_d = '0;
        else if (clk_en && state_q == ST_EXECUTE && retired_q != 16'hFFFF)
            retired_d = retired_q + 16'd1;
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) retired_q <= '0;
        else              retired_q <= retired_d;
    end

    assign retired_count = retired_q;
`endif

endmodule

// File: tb/tb_crash_course_cpu_sequencer.sv
// Directed bench: small imem with configurable ack wait and a register file model.
module tb_crash_course_cpu_sequencer;

    logic        clk = 1'b0;
    logic        async_rst_n = 1'b1;
    logic        clk_en = 1'b1;
    logic        start = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        system_enabled;
    logic [3:0]  reg_a_addr;
    logic        reg_a_write_enable;
    logic [7:0]  reg_a_write_data;
    logic [3:0]  reg_b_addr;
    logic [7:0]  reg_b_read_data;
    logic [3:0]  reg_c_addr;
    logic [7:0]  reg_c_read_data;
    logic        halted;
    logic        illegal_opcode;
`ifdef CRASH_COURSE_CPU_RETIRE_COUNT_EN
    logic [15:0] retired_count;
`endif

    logic [15:0] mem [256];
    logic [7:0]  regs [16];
    int          ack_wait = 0;
    int          req_cnt = 0;
    int          nf = 0, nw = 0, ill_cnt = 0;
    logic [7:0]  fetch_log [64];
    logic [3:0]  wa_log [64];
    logic [7:0]  wd_log [64];
    int          n_checks = 0, n_fails = 0;

    always #5 clk = ~clk;

    crash_course_cpu_sequencer dut (
        .clk                (clk),
        .async_rst_n        (async_rst_n),
        .clk_en             (clk_en),
        .start              (start),
        .imem_req           (imem_req),
        .imem_addr          (imem_addr),
        .imem_ack           (imem_ack),
        .imem_data          (imem_data),
        .system_enabled     (system_enabled),
        .reg_a_addr         (reg_a_addr),
        .reg_a_write_enable (reg_a_write_enable),
        .reg_a_write_data   (reg_a_write_data),
        .reg_b_addr         (reg_b_addr),
        .reg_b_read_data    (reg_b_read_data),
        .reg_c_addr         (reg_c_addr),
        .reg_c_read_data    (reg_c_read_data),
        .halted             (halted),
        .illegal_opcode     (illegal_opcode)
`ifdef CRASH_COURSE_CPU_RETIRE_COUNT_EN
        ,
        .retired_count      (retired_count)
`endif
    );

    assign imem_ack        = imem_req && (req_cnt >= ack_wait);
    assign imem_data       = mem[imem_addr];
    assign reg_b_read_data = regs[reg_b_addr];
    assign reg_c_read_data = regs[reg_c_addr];

    // Memory wait-state counter, register file and transaction logs.
    always @(posedge clk) begin
        if (!imem_req || (imem_ack && clk_en)) req_cnt <= 0;
        else                                   req_cnt <= req_cnt + 1;
        if (async_rst_n && clk_en) begin
            if (imem_req && imem_ack && nf < 64) begin
                fetch_log[nf] <= imem_addr;
                nf <= nf + 1;
            end
            if (reg_a_write_enable && nw < 64) begin
                wa_log[nw] <= reg_a_addr;
                wd_log[nw] <= reg_a_write_data;
                nw <= nw + 1;
                if (reg_a_addr != 4'd0) regs[reg_a_addr] <= reg_a_write_data;
            end
            if (illegal_opcode) ill_cnt <= ill_cnt + 1;
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic run_until_halt(input int max);
        for (int i = 0; i < max && !halted; i++) step(1);
        chk("halt_reached", {63'd0, halted}, 64'd1);
    endtask

    task automatic run_until_nf(input int target, input int max);
        for (int i = 0; i < max && nf < target; i++) step(1);
        chk("fetch_count_reached", nf, target);
    endtask

    int bf, bw, bi;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 16; i++) regs[i] = 8'h00;

        // Reset state
        #2 async_rst_n = 1'b0;
        #1;
        chk("reset_outputs", {imem_req, imem_addr, system_enabled, reg_a_addr, reg_a_write_enable,
             reg_a_write_data, reg_b_addr, reg_c_addr, halted, illegal_opcode}, 64'd0);
        step(2);
        async_rst_n = 1'b1;
        step(1);
        chk("idle_no_req", {63'd0, imem_req}, 64'd0);

        // Program 1: LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT
        mem[0] = 16'h6105; mem[1] = 16'h6203; mem[2] = 16'h1312; mem[3] = 16'hF000;
        bf = nf; bw = nw;
        pulse_start();
        chk("p1_req", {63'd0, imem_req}, 64'd1);
        chk("p1_addr0", imem_addr, 64'h00);
        chk("p1_sysen", {63'd0, system_enabled}, 64'd1);
        chk("p1_ack_zero_wait", {63'd0, imem_ack}, 64'd1);
        step(2);
        chk("p1_ldi_we", {63'd0, reg_a_write_enable}, 64'd1);
        chk("p1_ldi_addr", reg_a_addr, 64'd1);
        chk("p1_ldi_data", reg_a_write_data, 64'h05);
        step(9);
        chk("p1_not_halted_yet", {63'd0, halted}, 64'd0);
        step(1);
        chk("p1_halted_12", {63'd0, halted}, 64'd1);
        chk("p1_sysen_off", {63'd0, system_enabled}, 64'd0);
        chk("p1_nfetch", nf - bf, 64'd4);
        for (int i = 0; i < 4; i++) chk("p1_fetch_addr", fetch_log[bf+i], i);
        chk("p1_nwrite", nw - bw, 64'd3);
        chk("p1_w0", {wa_log[bw], wd_log[bw]}, 64'h105);
        chk("p1_w1", {wa_log[bw+1], wd_log[bw+1]}, 64'h203);
        chk("p1_w2_add", {wa_log[bw+2], wd_log[bw+2]}, 64'h308);
`ifdef CRASH_COURSE_CPU_RETIRE_COUNT_EN
        chk("p1_retired", retired_count, 64'd4);
`endif

        // Program 2: ALU ops, illegal, BZ taken / not taken
        mem[0] = 16'h2421; mem[1] = 16'h65FF; mem[2] = 16'h660F; mem[3] = 16'h5756;
        mem[4] = 16'h3856; mem[5] = 16'h4912; mem[6] = 16'h7A70; mem[7] = 16'hB000;
        mem[8] = 16'h9010; mem[16] = 16'h9120; mem[17] = 16'hF000;
        bf = nf; bw = nw; bi = ill_cnt;
        pulse_start();
        step(2);
        chk("p2_sub_addr", reg_a_addr, 64'd4);
        chk("p2_sub_data", reg_a_write_data, 64'hFE);
        run_until_halt(100);
        chk("p2_nwrite", nw - bw, 64'd7);
        chk("p2_w_xor", {wa_log[bw+3], wd_log[bw+3]}, 64'h7F0);
        chk("p2_w_and", {wa_log[bw+4], wd_log[bw+4]}, 64'h80F);
        chk("p2_w_or", {wa_log[bw+5], wd_log[bw+5]}, 64'h907);
        chk("p2_w_mov", {wa_log[bw+6], wd_log[bw+6]}, 64'hAF0);
        chk("p2_illegal_pulses", ill_cnt - bi, 64'd1);
        chk("p2_nfetch", nf - bf, 64'd11);
        chk("p2_after_illegal", fetch_log[bf+8], 64'h08);
        chk("p2_bz_taken", fetch_log[bf+9], 64'h10);
        chk("p2_bz_not_taken", fetch_log[bf+10], 64'h11);

        // Program 3: JMP 0xFF, NOP wraps to 0x00; delayed ack with clk_en toggling
        mem[0] = 16'h80FF; mem[255] = 16'h0000;
        bf = nf;
        pulse_start();
        run_until_nf(bf + 2, 20);
        ack_wait = 3;
        for (int i = 0; i < 10 && !imem_req; i++) step(1);
        chk("p3_wrap_req", {63'd0, imem_req}, 64'd1);
        chk("p3_wrap_addr", imem_addr, 64'h00);
        clk_en = 1'b1; step(1);
        chk("p3_w1_req_addr", {imem_req, imem_addr}, 64'h100);
        clk_en = 1'b0; step(1);
        chk("p3_w2_req_addr", {imem_req, imem_addr}, 64'h100);
        clk_en = 1'b1; step(1);
        chk("p3_w3_ack", {63'd0, imem_ack}, 64'd1);
        chk("p3_w3_nofetch", nf - bf, 64'd2);
        clk_en = 1'b0; step(1);
        chk("p3_ack_noen_hold", {imem_req, imem_addr}, 64'h100);
        chk("p3_ack_noen_nofetch", nf - bf, 64'd2);
        clk_en = 1'b1; step(1);
        chk("p3_transfer", nf - bf, 64'd3);
        chk("p3_decode_noreq", {63'd0, imem_req}, 64'd0);
        chk("p3_fetch_wrapped", fetch_log[bf+2], 64'h00);
        step(2);
        chk("p3_jmp_ff", {imem_req, imem_addr}, 64'h1FF);

        // Reset while fetching, then restart at RESET_PC
        async_rst_n = 1'b0;
        #1;
        chk("rst_mid_fetch", {imem_req, imem_addr, system_enabled, reg_a_addr, reg_a_write_enable,
             reg_a_write_data, reg_b_addr, reg_c_addr, halted, illegal_opcode}, 64'd0);
        step(1);
        async_rst_n = 1'b1;
        mem[0] = 16'hF000;
        ack_wait = 0;
        step(1);
        pulse_start();
        chk("restart_addr", {imem_req, imem_addr}, 64'h100);
        step(3);
        chk("restart_halt", {63'd0, halted}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
